fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised next-generation fetch unit. Sequentially prefetches instructions from the I-cache
//  into a QUEUE_DEPTH-entry FIFO of {pc, inst} pairs and presents them to decode via valid/ready.
//  Accepts PC redirects (branches/jumps) from the ALU, flushes the queue and discards stale
//  responses. Sits between the I-cache and the decode unit.
// PARAMETERS
//  DATA_WIDTH   32             instruction and address width
//  START_ADDR   32'h80000000   first fetch address after reset
//  QUEUE_DEPTH  4              FIFO entries; power of two, >= 2
//  PC_STEP      4              byte increment between sequential fetches
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous reset, active-low
//  inst_req        out  1           I-cache request, held until inst_valid
//  inst_addr       out  DATA_WIDTH  I-cache address, stable while inst_req=1
//  inst_valid      in   1           one-cycle response strobe, only while inst_req=1
//  inst_data       in   DATA_WIDTH  instruction word, qualified by inst_valid
//  inst_out_valid  out  1           queue head valid toward decode
//  inst_out_ready  in   1           decode accepts head
//  inst            out  DATA_WIDTH  head instruction
//  pc              out  DATA_WIDTH  address the head instruction was fetched from
//  redirect_valid  in   1           one-cycle redirect strobe from ALU
//  new_pc          in   DATA_WIDTH  redirect target; low 2 bits forced to 0
//  queue_count     out  $clog2(QUEUE_DEPTH+1)  current occupancy
// BEHAVIOUR
//  Reset (rst=0 at clk edge): inst_req=0, inst_addr=START_ADDR, inst_out_valid=0, inst=0, pc=0,
//   queue_count=0, FSM=IDLE, next fetch pc=START_ADDR. Reset mid-request abandons it; a pending
//   inst_valid is ignored.
//  FSM states:
//   IDLE     inst_req=0. If queue_count<QUEUE_DEPTH (count after this cycle's pop) -> WAIT_MEM.
//   WAIT_MEM inst_req=1 at fetch pc. On inst_valid: push {inst_addr, inst_data}; fetch
//            pc += PC_STEP. If room remains -> stay WAIT_MEM with new address (back-to-back),
//            else -> IDLE.
//   DRAIN    inst_req=1 at old address. On inst_valid: discard data -> IDLE.
//  First inst_req=1 is on the cycle after reset release.
//  Address arithmetic: modulo 2^DATA_WIDTH; wraps silently (0xFFFFFFFC+4 = 0x0).
//  At most one request outstanding. Issue is gated so the response can always be pushed.
//  Queue is registered. Data pushed in cycle N appears on inst/pc with inst_out_valid=1 in N+1.
//   Push and pop in the same cycle are both honoured and queue_count is unchanged.
//   Pop happens only when inst_out_valid & inst_out_ready. Outputs hold while not popped.
//  Redirect (redirect_valid=1), which has priority over everything except reset:
//   - Same-cycle pop completes, then the queue flushes: queue_count=0, inst_out_valid=0 next cycle.
//   - Fetch pc <= {new_pc[DW-1:2],2'b00}.
//   - IDLE -> WAIT_MEM at the new target next cycle.
//   - WAIT_MEM without inst_valid -> DRAIN.
//   - WAIT_MEM with inst_valid the same cycle: response discarded -> WAIT_MEM at the target next cycle.
//   - DRAIN: target overwritten, so the latest redirect wins; stay in DRAIN.
//  Sequential inst_valid in IDLE (protocol violation) is ignored.
// TESTING
//  1 Reset 3 cycles, release; cache responds 1 cycle after req, decode ready -> inst_addr
//    0x80000000,0x80000004,0x80000008; pc on decode port matches each address, in order.
//  2 inst_out_ready=0, immediate responses -> 4 pushes, queue_count=4, inst_req=0; pulse ready
//    for 1 cycle -> pc=0x80000000 popped, next req at 0x80000010.
//  3 Redirect new_pc=0x80000103 while req 0x80000008 is outstanding -> req held at 0x80000008 until
//    valid, data dropped, queue empty, next req 0x80000100, first delivered pc=0x80000100.
//  4 Redirect to 0x80000200 in the same cycle as inst_valid and a decode pop -> popped entry
//    delivered, response dropped, queue_count=0, next req 0x80000200.
//  5 START_ADDR=32'hFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//  6 rst=0 while in WAIT_MEM with queue_count=2 -> next cycle all outputs at reset values; after
//    release, first req is at START_ADDR.

Source files
------------

// File: rtl/fetch_queue.sv
// Sequential instruction prefetcher: fetches from the I-cache into a small {pc, inst} FIFO feeding decode.
// Latency: a response pushed on cycle N is visible at the decode port on N+1; one request outstanding at a time.
// Backpressure: decode stalls via inst_out_ready; fetch issue stops while the queue cannot take another entry.
module fetch_queue #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] START_ADDR  = 32'h80000000,
    parameter int                    QUEUE_DEPTH = 4,
    parameter int                    PC_STEP     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             inst_req,
    output logic [DATA_WIDTH-1:0]            inst_addr,
    input  logic                             inst_valid,
    input  logic [DATA_WIDTH-1:0]            inst_data,
    output logic                             inst_out_valid,
    input  logic                             inst_out_ready,
    output logic [DATA_WIDTH-1:0]            inst,
    output logic [DATA_WIDTH-1:0]            pc,
    input  logic                             redirect_valid,
    input  logic [DATA_WIDTH-1:0]            new_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] fetch_pc;   // next address to request from IDLE
    logic [DATA_WIDTH-1:0] req_addr;   // address currently presented to the I-cache
    logic [DATA_WIDTH-1:0] q_inst [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic                  pop;
    logic                  push;
    logic [CW-1:0]         count_pop;
    logic                  room_idle;
    logic                  room_after_push;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] next_seq;

    // Handshake, occupancy and address helpers shared by the FSM and the queue.
    always_comb begin
        pop             = inst_out_valid & inst_out_ready;
        // A redirect kills any response arriving in the same cycle.
        push            = (state == WAIT_MEM) & inst_valid & ~redirect_valid;
        count_pop       = count - CW'(pop);
        room_idle       = count_pop < CW'(QUEUE_DEPTH);
        // After this cycle's push, is there still space for one more response?
        room_after_push = count_pop < CW'(QUEUE_DEPTH - 1);
        target          = new_pc & ~DATA_WIDTH'(3);
        next_seq        = req_addr + DATA_WIDTH'(PC_STEP);
    end

    // Fetch FSM: issues one request at a time and tracks redirects against an in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= START_ADDR;
            req_addr <= START_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= target;
                        req_addr <= target;
                        state    <= WAIT_MEM;
                    end else if (room_idle) begin
                        req_addr <= fetch_pc;
                        state    <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (redirect_valid) begin
                        fetch_pc <= target;
                        if (inst_valid) begin
                            // Response already back: drop it and fetch the target right away.
                            req_addr <= target;
                        end else begin
                            // Keep the stale request up until the cache answers it.
                            state <= DRAIN;
                        end
                    end else if (inst_valid) begin
                        fetch_pc <= next_seq;
                        if (room_after_push) begin
                            req_addr <= next_seq;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    // A later redirect only updates the target; the stale request still drains.
                    if (redirect_valid) begin
                        fetch_pc <= target;
                    end else if (inst_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered FIFO of {pc, inst}; a redirect flushes it after any same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                q_inst[tail] <= inst_data;
                q_pc[tail]   <= req_addr;
            end
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                count <= count_pop + CW'(push);
            end
        end
    end

    assign inst_req       = (state != IDLE);
    assign inst_addr      = req_addr;
    assign inst_out_valid = (count != '0);
    assign inst           = q_inst[head];
    assign pc             = q_pc[head];
    assign queue_count    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for sequential fetch, backpressure and reset,
// plus hand-written sequences for redirects, wrap-around and reset during a pending fetch.
// One extra instance starts near the top of the address space to cover wrap-around.
module tb_fetch_queue;

    localparam logic [31:0] A = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_out_valid;
    logic        inst_out_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] new_pc;
    logic [2:0]  queue_count;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_iv;
    logic [31:0] w_idat;
    logic        w_ov;
    logic        w_rdy;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_rv;
    logic [31:0] w_npc;
    logic [2:0]  w_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_out_valid(inst_out_valid), .inst_out_ready(inst_out_ready),
        .inst(inst), .pc(pc),
        .redirect_valid(redirect_valid), .new_pc(new_pc),
        .queue_count(queue_count)
    );

    fetch_queue #(.START_ADDR(32'hFFFFFFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .inst_req(w_req), .inst_addr(w_addr),
        .inst_valid(w_iv), .inst_data(w_idat),
        .inst_out_valid(w_ov), .inst_out_ready(w_rdy),
        .inst(w_inst), .pc(w_pc),
        .redirect_valid(w_rv), .new_pc(w_npc),
        .queue_count(w_cnt)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] idat;
        logic        rdy;
        logic        e_req;
        logic        ca;      // compare inst_addr in this row
        logic [31:0] e_addr;
        logic        e_ov;
        logic        cd;      // compare pc/inst in this row
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic r, logic iv, logic [31:0] d, logic rdy,
                                logic ereq, logic ca, logic [31:0] ea, logic eov,
                                logic cd, logic [31:0] epc, logic [31:0] ei, logic [2:0] ec);
        vec_t v;
        v.rst = r; v.iv = iv; v.idat = d; v.rdy = rdy;
        v.e_req = ereq; v.ca = ca; v.e_addr = ea; v.e_ov = eov;
        v.cd = cd; v.e_pc = epc; v.e_inst = ei; v.e_cnt = ec;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Full decode-side / request-side snapshot for the hand-written sequences.
    task automatic snap(input string nm, input logic ereq, input logic [31:0] ea,
                        input logic eov, input logic [31:0] epc, input logic [2:0] ec);
        chk({nm, ".req"}, 32'(inst_req), 32'(ereq));
        if (ereq) chk({nm, ".addr"}, inst_addr, ea);
        chk({nm, ".ov"}, 32'(inst_out_valid), 32'(eov));
        if (eov) chk({nm, ".pc"}, pc, epc);
        chk({nm, ".cnt"}, 32'(queue_count), 32'(ec));
    endtask

    initial begin
        logic [31:0] wexp [3];

        rst = 1'b0; inst_valid = 1'b0; inst_data = '0; inst_out_ready = 1'b1;
        redirect_valid = 1'b0; new_pc = '0;
        w_iv = 1'b0; w_idat = '0; w_rdy = 1'b1; w_rv = 1'b0; w_npc = '0;

        //             rst iv  data          rdy  req ca addr     ov cd pc       inst          cnt
        vecs[0]  = mk(1, 0, 32'h0,        1,   0, 1, A,       0, 1, 32'h0,  32'h0,        0);
        vecs[1]  = mk(1, 0, 32'h0,        1,   1, 1, A,       0, 0, 32'h0,  32'h0,        0);
        vecs[2]  = mk(1, 1, 32'h11111111, 1,   1, 1, A,       0, 0, 32'h0,  32'h0,        0);
        vecs[3]  = mk(1, 0, 32'h0,        1,   1, 1, A+4,     1, 1, A,      32'h11111111, 1);
        vecs[4]  = mk(1, 1, 32'h22222222, 1,   1, 1, A+4,     0, 0, 32'h0,  32'h0,        0);
        vecs[5]  = mk(1, 0, 32'h0,        1,   1, 1, A+8,     1, 1, A+4,    32'h22222222, 1);
        vecs[6]  = mk(1, 1, 32'h33333333, 1,   1, 1, A+8,     0, 0, 32'h0,  32'h0,        0);
        vecs[7]  = mk(1, 0, 32'h0,        1,   1, 1, A+12,    1, 1, A+8,    32'h33333333, 1);
        vecs[8]  = mk(0, 1, 32'hDEADDEAD, 1,   1, 1, A+12,    0, 0, 32'h0,  32'h0,        0);
        vecs[9]  = mk(1, 1, 32'h0BAD0BAD, 0,   0, 1, A,       0, 1, 32'h0,  32'h0,        0);
        vecs[10] = mk(1, 1, 32'hA0000000, 0,   1, 1, A,       0, 0, 32'h0,  32'h0,        0);
        vecs[11] = mk(1, 1, 32'hA0000001, 0,   1, 1, A+4,     1, 1, A,      32'hA0000000, 1);
        vecs[12] = mk(1, 1, 32'hA0000002, 0,   1, 1, A+8,     1, 1, A,      32'hA0000000, 2);
        vecs[13] = mk(1, 1, 32'hA0000003, 0,   1, 1, A+12,    1, 1, A,      32'hA0000000, 3);
        vecs[14] = mk(1, 0, 32'h0,        1,   0, 0, 32'h0,   1, 1, A,      32'hA0000000, 4);
        vecs[15] = mk(1, 0, 32'h0,        0,   1, 1, A+16,    1, 1, A+4,    32'hA0000001, 3);
        vecs[16] = mk(1, 0, 32'h0,        0,   1, 1, A+16,    1, 1, A+4,    32'hA0000001, 3);

        // Three reset cycles before the table starts.
        tick(); tick(); tick();

        for (int i = 0; i < 17; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".req"}, 32'(inst_req), 32'(vecs[i].e_req));
            if (vecs[i].ca) chk({tag, ".addr"}, inst_addr, vecs[i].e_addr);
            chk({tag, ".ov"}, 32'(inst_out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].cd) begin
                chk({tag, ".pc"}, pc, vecs[i].e_pc);
                chk({tag, ".inst"}, inst, vecs[i].e_inst);
            end
            chk({tag, ".cnt"}, 32'(queue_count), 32'(vecs[i].e_cnt));
            rst            = vecs[i].rst;
            inst_valid     = vecs[i].iv;
            inst_data      = vecs[i].idat;
            inst_out_ready = vecs[i].rdy;
            tick();
        end

        // Redirect while a request is outstanding: the stale request drains first.
        rst = 1'b0; inst_valid = 1'b0; inst_out_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        snap("rd.start", 1, A, 0, 0, 0);
        inst_valid = 1'b1; inst_data = 32'h00000051;
        tick();
        inst_data = 32'h00000052;
        snap("rd.first", 1, A + 4, 1, A, 1);
        tick();
        inst_valid = 1'b0; inst_out_ready = 1'b0;
        redirect_valid = 1'b1; new_pc = 32'h80000103;
        snap("rd.pre", 1, A + 8, 1, A + 4, 1);
        tick();
        redirect_valid = 1'b0;
        snap("rd.flush", 1, A + 8, 0, 0, 0);
        tick();
        snap("rd.hold", 1, A + 8, 0, 0, 0);
        inst_valid = 1'b1; inst_data = 32'h00000BAD;
        tick();
        inst_valid = 1'b0;
        snap("rd.dropped", 0, 0, 0, 0, 0);
        tick();
        snap("rd.target", 1, 32'h80000100, 0, 0, 0);
        inst_valid = 1'b1; inst_data = 32'h0000C0DE;
        tick();
        inst_valid = 1'b0;
        snap("rd.deliver", 1, 32'h80000104, 1, 32'h80000100, 1);
        chk("rd.inst", inst, 32'h0000C0DE);

        // Redirect coinciding with a response and a decode pop.
        inst_out_ready = 1'b1; inst_valid = 1'b1; inst_data = 32'h0000BEEF;
        redirect_valid = 1'b1; new_pc = 32'h80000200;
        tick();
        redirect_valid = 1'b0; inst_valid = 1'b0; inst_out_ready = 1'b0;
        snap("rv.flush", 1, 32'h80000200, 0, 0, 0);
        inst_valid = 1'b1; inst_data = 32'h0000200D;
        tick();
        inst_valid = 1'b0;
        snap("rv.deliver", 1, 32'h80000204, 1, 32'h80000200, 1);
        chk("rv.inst", inst, 32'h0000200D);

        // Reset while a fetch is pending with two queued entries.
        inst_valid = 1'b1; inst_data = 32'h00000077;
        tick();
        inst_valid = 1'b0;
        snap("rs.before", 1, 32'h80000208, 1, 32'h80000200, 2);
        rst = 1'b0;
        tick();
        snap("rs.during", 0, 0, 0, 0, 0);
        chk("rs.addr", inst_addr, A);
        chk("rs.inst", inst, 32'h0);
        chk("rs.pc", pc, 32'h0);
        rst = 1'b1;
        tick();
        snap("rs.release", 1, A, 0, 0, 0);

        // Address wrap-around on the instance starting at 0xFFFFFFF8.
        wexp[0] = 32'hFFFFFFF8; wexp[1] = 32'hFFFFFFFC; wexp[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap%0d.req", i), 32'(w_req), 32'h1);
            chk($sformatf("wrap%0d.addr", i), w_addr, wexp[i]);
            if (i > 0) chk($sformatf("wrap%0d.pc", i), w_pc, wexp[i-1]);
            w_iv = 1'b1; w_idat = 32'(i);
            tick();
        end
        w_iv = 1'b0;
        chk("wrap.last_pc", w_pc, 32'h00000000);
        chk("wrap.last_ov", 32'(w_ov), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
